// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
`ifndef DMEM_ARBITER_DEFS
`define DMEM_ARBITER_DEFS
`define REG_RANGE 31:0
`define FUNCT_3_RANGE 2:0
`endif
package dmem_arbiter_pkg;
  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_t;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// dmem_arbiter_starve_counter: counts denied host cycles and raises a one-cycle forced host slot.
module dmem_arbiter_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_req,
  input  logic       host_gnt,
  output arb_state_t state
);
  logic [7:0] wait_cnt, wait_cnt_next;
  arb_state_t state_next;
  always_comb begin
    state_next = state;
    wait_cnt_next = 8'd0;
    if (state == ARB_NORMAL && host_req && !host_gnt) begin
      state_next = (wait_cnt == 8'(STARVE_LIMIT - 1)) ? ARB_FORCE : ARB_NORMAL;
      wait_cnt_next = (wait_cnt == 8'(STARVE_LIMIT - 1)) ? wait_cnt : wait_cnt + 8'd1;
    end else if (state == ARB_FORCE) begin
      state_next = ARB_NORMAL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_NORMAL;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core MEM stage (priority) and a host port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE = 1024,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req,
  input  logic             core_wr_en,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [2:0]       core_funct3,
  input  logic [WIDTH-1:0] core_wr_data,
  output logic             core_stall,
  output logic [WIDTH-1:0] core_rd_data,
  input  logic             host_req,
  input  logic             host_wr_en,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wr_data,
  output logic             host_gnt,
  output logic [WIDTH-1:0] host_rd_data,
  output logic             host_rd_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wr_en,
  output logic [2:0]       mem_funct3,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data
);
  arb_state_t state;
  dmem_arbiter_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_counter (
    .clk(clk),
    .rst(rst),
    .host_req(host_req),
    .host_gnt(host_gnt),
    .state(state)
  );
  always_comb begin
    host_gnt = host_req && (state == ARB_FORCE || !core_req);
    core_stall = state == ARB_FORCE && core_req && host_req;
    mem_addr = host_gnt ? WIDTH'({host_addr, 2'b00}) : core_addr;
    mem_funct3 = host_gnt ? FUNCT3_WORD : core_funct3;
    mem_wr_data = host_gnt ? host_wr_data : core_wr_data;
    mem_wr_en = host_gnt ? host_wr_en : core_req && core_wr_en;
    core_rd_data = mem_rd_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rd_valid <= 1'b0;
      host_rd_data <= '0;
    end else begin
      host_rd_valid <= host_gnt && !host_wr_en;
      if (host_gnt && !host_wr_en) host_rd_data <= mem_rd_data;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a simple backing memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic core_req, core_wr_en, core_stall, host_req, host_wr_en, host_gnt, host_rd_valid, mem_wr_en;
  logic [31:0] core_addr, core_wr_data, core_rd_data, host_wr_data, host_rd_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [2:0] core_funct3, mem_funct3;
  logic [9:0] host_addr;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[11:2]] <= mem_wr_data;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_funct3(core_funct3), .core_wr_data(core_wr_data),
    .core_stall(core_stall), .core_rd_data(core_rd_data),
    .host_req(host_req), .host_wr_en(host_wr_en), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_gnt(host_gnt),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h1234_5678;
    mem[6] = 32'hCAFE_F00D;
    rst = 1'b1; core_req = 0; core_wr_en = 0; core_addr = 0; core_funct3 = 0; core_wr_data = 0;
    host_req = 0; host_wr_en = 0; host_addr = 0; host_wr_data = 0;
    tick; tick;
    rst = 1'b0;
    #2;
    chk("rst_valid", host_rd_valid, 1'b0);
    chk("rst_data", host_rd_data, 32'h0);
    chk("rst_gnt", host_gnt, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    tick;
    core_req = 1; core_addr = 32'h10; core_funct3 = 3'b100;
    #2;
    chk("core_addr", mem_addr, 32'h10);
    chk("core_funct3", mem_funct3, 3'b100);
    chk("core_rd", core_rd_data, 32'h1234_5678);
    chk("core_stall", core_stall, 1'b0);
    chk("core_hgnt", host_gnt, 1'b0);
    tick;
    core_req = 0; host_req = 1; host_wr_en = 1; host_addr = 10'd5; host_wr_data = 32'hDEAD_BEEF;
    #2;
    chk("hw_gnt", host_gnt, 1'b1);
    chk("hw_addr", mem_addr, 32'h14);
    chk("hw_funct3", mem_funct3, 3'b010);
    chk("hw_wr_en", mem_wr_en, 1'b1);
    chk("hw_data", mem_wr_data, 32'hDEAD_BEEF);
    tick;
    chk("hw_no_valid", host_rd_valid, 1'b0);
    host_wr_en = 0;
    #2;
    chk("hr_gnt", host_gnt, 1'b1);
    chk("hr_wr_en", mem_wr_en, 1'b0);
    tick;
    chk("hr_valid", host_rd_valid, 1'b1);
    chk("hr_data", host_rd_data, 32'hDEAD_BEEF);
    host_req = 0;
    tick;
    chk("hr_pulse", host_rd_valid, 1'b0);
    chk("hr_hold", host_rd_data, 32'hDEAD_BEEF);
    core_req = 1; core_wr_en = 1; core_addr = 32'h40; core_funct3 = 3'b010; core_wr_data = 32'hA5;
    host_req = 1; host_wr_en = 0; host_addr = 10'd6;
    for (int c = 0; c < 15; c++) begin
      #2;
      chk("ct_gnt", host_gnt, 1'((c % 5) == 4));
      chk("ct_stall", core_stall, 1'((c % 5) == 4));
      chk("ct_wr_en", mem_wr_en, 1'((c % 5) != 4));
      chk("ct_addr", mem_addr, ((c % 5) == 4) ? 32'h18 : 32'h40);
      tick;
      chk("ct_valid", host_rd_valid, 1'((c % 5) == 4));
      if ((c % 5) == 4) chk("ct_rdata", host_rd_data, 32'hCAFE_F00D);
    end
    for (int c = 0; c < 9; c++) begin
      host_req = (c != 2);
      #2;
      chk("wd_gnt", host_gnt, 1'(c == 7));
      chk("wd_stall", core_stall, 1'(c == 7));
      tick;
    end
    host_req = 0;
    tick;
    host_req = 1;
    for (int c = 0; c < 10; c++) begin
      host_req = (c != 4);
      #2;
      chk("fd_gnt", host_gnt, 1'(c == 9));
      chk("fd_stall", core_stall, 1'(c == 9));
      if (c == 4) begin
        chk("fd_wr_en", mem_wr_en, 1'b1);
        chk("fd_addr", mem_addr, 32'h40);
      end
      tick;
    end
    host_req = 0;
    tick;
    host_req = 1;
    for (int c = 0; c < 4; c++) tick;
    rst = 1;
    #2;
    chk("rs_force_gnt", host_gnt, 1'b1);
    tick;
    rst = 0; core_req = 0; host_req = 0;
    #2;
    chk("rs_valid", host_rd_valid, 1'b0);
    chk("rs_data", host_rd_data, 32'h0);
    core_req = 1; host_req = 1;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("rs_gnt", host_gnt, 1'(c == 4));
      tick;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
